mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 256x8 single-port memory (rd/wr/addr/Din/Dout). It accepts independent read/write requests from ports A and B and serialises them onto the memory strobes. It captures read data per requester and returns a one-cycle completion pulse. It sits between the memory and its two clients.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t      : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   REQ_A/REQ_B  : requester identifiers used by the picker and owner register
//   AW_DEF/DW_DEF: default address/data widths for the 256x8 memory
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
//   req[1:0] : request vector, bit REQ_A = port A, bit REQ_B = port B
//   last_id  : requester granted most recently
//   gnt_id   : chosen requester (meaningful only when valid=1)
//   valid    : at least one request present
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_id,
    output logic       gnt_id,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        gnt_id = REQ_A;
        if (req == 2'b11) begin
            // Contention: the port that was not served last goes next.
            gnt_id = ~last_id;
        end else if (req[REQ_B]) begin
            gnt_id = REQ_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port memory.
// Serialises read/write requests from ports A and B onto the memory strobes,
// captures read data per requester and pulses done on completion.
//   clk, rst                    : clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   : port A request (held until a_gnt)
//   a_gnt/a_done/a_rdata        : port A grant pulse, completion pulse, read data
//   b_*                         : same as port A, for port B
//   mem_rd/mem_wr/mem_addr/mem_din/mem_dout : memory interface
//   busy                        : high whenever the sequencer is not IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          last_reg, last_next;
    logic          we_reg, we_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] a_rdata_reg, a_rdata_next;
    logic [DW-1:0] b_rdata_reg, b_rdata_next;

    logic pick_id;
    logic pick_valid;

    rr_arb2 u_pick (
        .req     ({b_req, a_req}),
        .last_id (last_reg),
        .gnt_id  (pick_id),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            owner_reg   <= REQ_A;
            last_reg    <= REQ_B;   // A wins the first tie after reset
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            cnt_reg     <= '0;
            a_rdata_reg <= '0;
            b_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            cnt_reg     <= cnt_next;
            a_rdata_reg <= a_rdata_next;
            b_rdata_reg <= b_rdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        cnt_next     = cnt_reg;
        a_rdata_next = a_rdata_reg;
        b_rdata_next = b_rdata_reg;
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        a_done       = 1'b0;
        b_done       = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;

        case (state_reg)
            IDLE: begin
                // Requests are only sampled here; anything arriving while
                // an operation is in flight waits for the return to IDLE.
                if (pick_valid) begin
                    owner_next = pick_id;
                    last_next  = pick_id;
                    if (pick_id == REQ_B) begin
                        we_next    = b_we;
                        addr_next  = b_addr;
                        wdata_next = b_wdata;
                    end else begin
                        we_next    = a_we;
                        addr_next  = a_addr;
                        wdata_next = a_wdata;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                a_gnt = (owner_reg == REQ_A);
                b_gnt = (owner_reg == REQ_B);
                if (we_reg) begin
                    mem_wr     = 1'b1;
                    state_next = DONE;
                end else begin
                    mem_rd     = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                mem_rd = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    // mem_rd has now been held RD_LAT cycles past issue.
                    if (owner_reg == REQ_A) begin
                        a_rdata_next = mem_dout;
                    end else begin
                        b_rdata_next = mem_dout;
                    end
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                a_done     = (owner_reg == REQ_A);
                b_done     = (owner_reg == REQ_B);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr = addr_reg;
    assign mem_din  = wdata_reg;
    assign a_rdata  = a_rdata_reg;
    assign b_rdata  = b_rdata_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: instance 0 built with RD_LAT=1,
// instance 1 with RD_LAT=3, each attached to its own behavioural memory
// that only returns valid data once mem_rd has been held RD_LAT cycles.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic       a_req [2];
    logic       a_we [2];
    logic [7:0] a_addr [2];
    logic [7:0] a_wdata [2];
    logic       b_req [2];
    logic       b_we [2];
    logic [7:0] b_addr [2];
    logic [7:0] b_wdata [2];
    logic       a_gnt [2];
    logic       a_done [2];
    logic [7:0] a_rdata [2];
    logic       b_gnt [2];
    logic       b_done [2];
    logic [7:0] b_rdata [2];
    logic       mem_rd [2];
    logic       mem_wr [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_din [2];
    logic [7:0] mem_dout [2];
    logic       busy [2];

    logic [7:0] mem [2][256];
    int         hcnt [2];
    logic [7:0] exp_a [2];
    logic [7:0] exp_b [2];

    int n_chk;
    int n_fail;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mem_arbiter #(
                .AW     (8),
                .DW     (8),
                .RD_LAT ((gi == 0) ? 1 : 3)
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .a_req    (a_req[gi]),
                .a_we     (a_we[gi]),
                .a_addr   (a_addr[gi]),
                .a_wdata  (a_wdata[gi]),
                .a_gnt    (a_gnt[gi]),
                .a_done   (a_done[gi]),
                .a_rdata  (a_rdata[gi]),
                .b_req    (b_req[gi]),
                .b_we     (b_we[gi]),
                .b_addr   (b_addr[gi]),
                .b_wdata  (b_wdata[gi]),
                .b_gnt    (b_gnt[gi]),
                .b_done   (b_done[gi]),
                .b_rdata  (b_rdata[gi]),
                .mem_rd   (mem_rd[gi]),
                .mem_wr   (mem_wr[gi]),
                .mem_addr (mem_addr[gi]),
                .mem_din  (mem_din[gi]),
                .mem_dout (mem_dout[gi]),
                .busy     (busy[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Memory model: data is garbage (EE) until mem_rd has been held long enough.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wr[d]) mem[d][mem_addr[d]] <= mem_din[d];
            if (rst || !mem_rd[d]) begin
                hcnt[d]     <= 0;
                mem_dout[d] <= 8'hEE;
            end else begin
                hcnt[d]     <= hcnt[d] + 1;
                mem_dout[d] <= (hcnt[d] + 1 >= lat_of(d)) ? mem[d][mem_addr[d]] : 8'hEE;
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_a[d] = 8'h00;
            exp_b[d] = 8'h00;
        end
    endtask

    // One isolated transaction, called at a negedge with the arbiter idle.
    task automatic run_txn(input int d, input logic port, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdat);
        int lat;
        lat = lat_of(d);
        chk1("pre_busy", busy[d], 1'b0);
        if (port == REQ_A) begin
            a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wdata;
        end else begin
            b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wdata;
        end
        @(negedge clk);
        chk1("issue_a_gnt", a_gnt[d], port == REQ_A);
        chk1("issue_b_gnt", b_gnt[d], port == REQ_B);
        chk1("issue_wr", mem_wr[d], we);
        chk1("issue_rd", mem_rd[d], !we);
        chk8("issue_addr", mem_addr[d], addr);
        if (we) chk8("issue_din", mem_din[d], wdata);
        // Requester saw gnt: drop req and scramble fields.
        a_req[d] = 1'b0; b_req[d] = 1'b0;
        a_addr[d] = ~addr; b_addr[d] = ~addr; a_wdata[d] = ~wdata; b_wdata[d] = ~wdata;
        a_we[d] = !we; b_we[d] = !we;
        if (!we) begin
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                chk1("wait_rd", mem_rd[d], 1'b1);
                chk1("wait_wr", mem_wr[d], 1'b0);
                chk8("wait_addr", mem_addr[d], addr);
                chk1("wait_no_done", a_done[d] | b_done[d], 1'b0);
            end
        end
        @(negedge clk);
        if (!we) begin
            if (port == REQ_A) exp_a[d] = rdat;
            else               exp_b[d] = rdat;
        end
        chk1("done_a", a_done[d], port == REQ_A);
        chk1("done_b", b_done[d], port == REQ_B);
        chk1("done_strobes", mem_rd[d] | mem_wr[d], 1'b0);
        chk8("a_rdata", a_rdata[d], exp_a[d]);
        chk8("b_rdata", b_rdata[d], exp_b[d]);
        @(negedge clk);
        chk1("post_busy", busy[d], 1'b0);
        chk1("post_done", a_done[d] | b_done[d], 1'b0);
        $display("txn dut=%0d port=%s we=%0d addr=%02h wdata=%02h a_rdata=%02h b_rdata=%02h",
                 d, (port == REQ_A) ? "A" : "B", we, addr, wdata, a_rdata[d], b_rdata[d]);
    endtask

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = 8'h00; a_wdata[d] = 8'h00;
            b_req[d] = 1'b0; b_we[d] = 1'b0; b_addr[d] = 8'h00; b_wdata[d] = 8'h00;
            exp_a[d] = 8'h00; exp_b[d] = 8'h00;
        end

        tbl[0] = '{REQ_A, 1'b1, 8'h4E, 8'h08, 8'h00};
        tbl[1] = '{REQ_A, 1'b0, 8'h4E, 8'h00, 8'h08};
        tbl[2] = '{REQ_B, 1'b1, 8'hFF, 8'h5A, 8'h00};
        tbl[3] = '{REQ_B, 1'b0, 8'hFF, 8'h00, 8'h5A};
        tbl[4] = '{REQ_A, 1'b1, 8'h00, 8'hC3, 8'h00};
        tbl[5] = '{REQ_A, 1'b0, 8'h00, 8'h00, 8'hC3};
        tbl[6] = '{REQ_B, 1'b0, 8'h4E, 8'h00, 8'h08};
        tbl[7] = '{REQ_A, 1'b1, 8'h4E, 8'h99, 8'h00};

        // Reset values
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("rst_busy", busy[d], 1'b0);
            chk1("rst_rd", mem_rd[d], 1'b0);
            chk1("rst_wr", mem_wr[d], 1'b0);
            chk1("rst_gnt", a_gnt[d] | b_gnt[d], 1'b0);
            chk1("rst_done", a_done[d] | b_done[d], 1'b0);
            chk8("rst_addr", mem_addr[d], 8'h00);
            chk8("rst_din", mem_din[d], 8'h00);
            chk8("rst_a_rdata", a_rdata[d], 8'h00);
            chk8("rst_b_rdata", b_rdata[d], 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single transactions, RD_LAT=1
        for (int i = 0; i < 8; i++) begin
            run_txn(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdat);
        end

        // Continuous contention after reset: A, B, A, B ...
        apply_reset();
        a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 8'h62; a_wdata[0] = 8'd15;
        b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 8'hF0; b_wdata[0] = 8'd27;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk1("cont_a_gnt", a_gnt[0], (c == 1) || (c == 7));
            chk1("cont_b_gnt", b_gnt[0], (c == 4) || (c == 10));
            chk1("cont_a_done", a_done[0], (c == 2) || (c == 8));
            chk1("cont_b_done", b_done[0], (c == 5) || (c == 11));
            chk1("cont_rdwr_excl", mem_rd[0] & mem_wr[0], 1'b0);
            if (a_gnt[0] || b_gnt[0])
                $display("txn dut=0 contention cycle=%0d a_gnt=%0b b_gnt=%0b", c, a_gnt[0], b_gnt[0]);
        end
        a_req[0] = 1'b0; b_req[0] = 1'b0;

        // Lone B held high right after B was last granted: served every time
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'hF0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk1("lone_b_gnt", b_gnt[0], (c % 4) == 1);
            chk1("lone_b_done", b_done[0], (c % 4) == 3);
            chk1("lone_a_gnt", a_gnt[0], 1'b0);
            if ((c % 4) == 3) begin
                chk8("lone_b_rdata", b_rdata[0], 8'd27);
                $display("txn dut=0 lone B read F0 cycle=%0d b_rdata=%02h", c, b_rdata[0]);
            end
        end
        b_req[0] = 1'b0;
        exp_b[0] = 8'd27;

        // Reset during WAIT of a read to AA
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 8'hAA;
        @(negedge clk);
        chk1("rstmid_gnt", a_gnt[0], 1'b1);
        a_req[0] = 1'b0;
        @(negedge clk);
        chk1("rstmid_wait_rd", mem_rd[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("rstmid_rd_drop", mem_rd[0], 1'b0);
        chk1("rstmid_busy", busy[0], 1'b0);
        chk8("rstmid_a_rdata", a_rdata[0], 8'h00);
        chk8("rstmid_b_rdata", b_rdata[0], 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_a[d] = 8'h00; exp_b[d] = 8'h00;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("rstmid_no_done", a_done[0] | b_done[0], 1'b0);
            chk1("rstmid_idle", busy[0], 1'b0);
        end
        $display("txn dut=0 read AA abandoned by reset");

        // Pointer back at B: a tie goes to A first
        a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 8'h01; a_wdata[0] = 8'h11;
        b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 8'h02; b_wdata[0] = 8'h22;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk1("ptr_a_gnt", a_gnt[0], c == 1);
            chk1("ptr_b_gnt", b_gnt[0], c == 4);
            if (c == 1) a_req[0] = 1'b0;
            if (c == 4) b_req[0] = 1'b0;
        end
        $display("txn dut=0 tie after mid-op reset granted A then B");

        // RD_LAT=3 build
        run_txn(1, REQ_B, 1'b1, 8'hF0, 8'd27, 8'h00);
        run_txn(1, REQ_A, 1'b0, 8'hF0, 8'h00, 8'd27);
        run_txn(1, REQ_B, 1'b0, 8'hF0, 8'h00, 8'd27);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
